mem_access_ctrl: RTL and testbench

Sequencing controller between the Memory2 pipeline stage and the data cache. It accepts one load/store per instruction from Memory2 and checks alignment and the TLB result. It then runs the request/ready handshake with the DCache and stalls the pipeline until the access completes. Load data is extracted and sign/zero-extended, and store data is replicated with byte strobes.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_align.sv | 60 ++++++
 rtl/mem_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the Memory2 / DCache access path.
package mem_pkg;

   // Access type, shared by memory_rw and cache_rw
   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_READ  = 2'b01;
   localparam logic [1:0] RW_WRITE = 2'b10;

   // Access size, number_length[1:0]; 2'b11 behaves as a word
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Access controller states
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b01;
   localparam logic [1:0] ST_DRAIN = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   // Natural alignment test: halves need addr[0]=0, words (and size 11) need addr[1:0]=0
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = addr_lo[0];
         default: mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data formatting for memory accesses: load lane extract with
// sign/zero extension, and store lane replication with byte strobes.
module mem_align
   import mem_pkg::*;
(
   input  logic        [1:0]  ld_size,
   input  logic               ld_unsigned,
   input  logic        [1:0]  ld_addr,
   input  logic        [31:0] ld_raw,
   output logic        [31:0] ld_data,
   input  logic        [1:0]  st_size,
   input  logic        [1:0]  st_addr,
   input  logic        [31:0] st_raw,
   output logic        [31:0] st_data,
   output logic        [3:0]  st_strb
);

   logic signed [7:0]  ld_byte;
   logic signed [15:0] ld_half;

   // Select the addressed byte/half lane and extend it to a full word
   always_comb begin
      ld_byte = '0;
      ld_half = '0;
      ld_data = ld_raw;
      case (ld_addr)
         2'd0:    ld_byte = ld_raw[7:0];
         2'd1:    ld_byte = ld_raw[15:8];
         2'd2:    ld_byte = ld_raw[23:16];
         default: ld_byte = ld_raw[31:24];
      endcase
      ld_half = ld_addr[1] ? ld_raw[31:16] : ld_raw[15:0];
      case (ld_size)
         SZ_BYTE: ld_data = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_data = ld_raw;
      endcase
   end

   // Replicate the store operand across all lanes and enable only the addressed bytes
   always_comb begin
      st_data = st_raw;
      st_strb = 4'b1111;
      case (st_size)
         SZ_BYTE: begin
            st_data = {4{st_raw[7:0]}};
            st_strb = 4'b0001 << st_addr;
         end
         SZ_HALF: begin
            st_data = {2{st_raw[15:0]}};
            st_strb = 4'b0011 << st_addr;
         end
         default: begin
            st_data = st_raw;
            st_strb = 4'b1111;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory2 <-> DCache access sequencer: alignment/TLB checks, request/ready
// handshake with pipeline stall, flush draining and load/store formatting.
module mem_access_ctrl
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  memory_rw,
   input  logic [2:0]  number_length,
   input  logic [31:0] v_addr,
   input  logic [31:0] store_data,
   input  logic        flush,
   input  logic        tlb_hit,
   input  logic [19:0] tlb_ppn,
   output logic [31:0] p_addr,
   output logic        p_addr_valid,
   output logic [1:0]  cache_rw,
   output logic [31:0] cache_write,
   output logic [3:0]  cache_wstrb,
   input  logic        cache_ready,
   input  logic [31:0] cache_read,
   output logic [31:0] mem_result,
   output logic        stall,
   output logic        excp_ale,
   output logic        excp_tlbr
);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [31:0] p_addr_r;
   logic [1:0]  rw_r;
   logic [1:0]  size_r;
   logic        unsigned_r;
   logic [1:0]  addr_lo_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;
   logic [31:0] result_r;

   logic        is_mem;
   logic        access;
   logic        misaligned;
   logic        ale;
   logic        tlbr;
   logic        accept;
   logic        load_done;
   logic [31:0] ld_data;
   logic [31:0] st_data;
   logic [3:0]  st_strb;

   // The upper virtual address bits are replaced by the PPN and never needed here
   logic        unused_vpn;
   assign unused_vpn = ^v_addr[31:12];

   mem_align u_align (
      .ld_size     (size_r),
      .ld_unsigned (unsigned_r),
      .ld_addr     (addr_lo_r),
      .ld_raw      (cache_read),
      .ld_data     (ld_data),
      .st_size     (number_length[1:0]),
      .st_addr     (v_addr[1:0]),
      .st_raw      (store_data),
      .st_data     (st_data),
      .st_strb     (st_strb)
   );

   // Classify the Memory2 instruction while idle; ALE outranks TLB refill
   always_comb begin
      is_mem     = (memory_rw == RW_READ) || (memory_rw == RW_WRITE);
      access     = (state == ST_IDLE) && req_valid && is_mem && !flush;
      misaligned = is_misaligned(number_length[1:0], v_addr[1:0]);
      ale        = access && misaligned;
      tlbr       = access && !misaligned && !tlb_hit;
      accept     = access && !misaligned && tlb_hit;
      // A flush arriving together with ready discards the data just like DRAIN
      load_done  = (state == ST_BUSY) && cache_ready && !flush && (rw_r == RW_READ);
   end

   // Next-state logic; an issued cache request always runs to cache_ready
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_BUSY;
         end
         ST_BUSY: begin
            if (cache_ready)
               state_nxt = flush ? ST_IDLE : ST_DONE;
            else if (flush)
               state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (cache_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register, request latches captured at accept, and the load result register
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         p_addr_r   <= '0;
         rw_r       <= RW_NONE;
         size_r     <= '0;
         unsigned_r <= 1'b0;
         addr_lo_r  <= '0;
         wdata_r    <= '0;
         wstrb_r    <= '0;
         result_r   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            p_addr_r   <= {tlb_ppn, v_addr[11:0]};
            rw_r       <= memory_rw;
            size_r     <= number_length[1:0];
            unsigned_r <= number_length[2];
            addr_lo_r  <= v_addr[1:0];
            wdata_r    <= st_data;
            wstrb_r    <= (memory_rw == RW_WRITE) ? st_strb : 4'b0000;
         end
         if (load_done) result_r <= ld_data;
      end
   end

   // Drive outputs from state and latches; everything reads 0 while reset is held
   always_comb begin
      p_addr       = '0;
      p_addr_valid = 1'b0;
      cache_rw     = RW_NONE;
      cache_write  = '0;
      cache_wstrb  = '0;
      mem_result   = '0;
      stall        = 1'b0;
      excp_ale     = 1'b0;
      excp_tlbr    = 1'b0;
      if (!rst) begin
         p_addr       = p_addr_r;
         p_addr_valid = (state == ST_BUSY) || (state == ST_DRAIN);
         cache_rw     = p_addr_valid ? rw_r : RW_NONE;
         cache_write  = wdata_r;
         cache_wstrb  = wstrb_r;
         mem_result   = result_r;
         stall        = accept || p_addr_valid;
         excp_ale     = ale;
         excp_tlbr    = tlbr;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues directed and random
// Memory2 instructions and queues expected DCache requests/exceptions/results;
// a monitor compares them when the DUT presents them.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [1:0]  memory_rw;
   logic [2:0]  number_length;
   logic [31:0] v_addr;
   logic [31:0] store_data;
   logic        flush;
   logic        tlb_hit;
   logic [19:0] tlb_ppn;
   logic [31:0] p_addr;
   logic        p_addr_valid;
   logic [1:0]  cache_rw;
   logic [31:0] cache_write;
   logic [3:0]  cache_wstrb;
   logic        cache_ready;
   logic [31:0] cache_read;
   logic [31:0] mem_result;
   logic        stall;
   logic        excp_ale;
   logic        excp_tlbr;

   mem_access_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .memory_rw     (memory_rw),
      .number_length (number_length),
      .v_addr        (v_addr),
      .store_data    (store_data),
      .flush         (flush),
      .tlb_hit       (tlb_hit),
      .tlb_ppn       (tlb_ppn),
      .p_addr        (p_addr),
      .p_addr_valid  (p_addr_valid),
      .cache_rw      (cache_rw),
      .cache_write   (cache_write),
      .cache_wstrb   (cache_wstrb),
      .cache_ready   (cache_ready),
      .cache_read    (cache_read),
      .mem_result    (mem_result),
      .stall         (stall),
      .excp_ale      (excp_ale),
      .excp_tlbr     (excp_tlbr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {K_ALE, K_TLBR, K_ACC} kind_t;
   typedef struct {
      kind_t       kind;
      logic [31:0] paddr;
      logic [1:0]  rw;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] result;
      int          waits;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_last;
   int          n_pass;
   int          n_total;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
   endtask

   // Reference load formatting from the lane/extension rules
   function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [2:0] nl, input logic [1:0] a);
      int unsigned v;
      int unsigned rdu;
      rdu = rd;
      case (nl[1:0])
         2'b00: begin
            v = (rdu >> (8 * int'(a))) % 256;
            if (!nl[2] && v >= 128) v = v + 32'hFFFF_FF00;
         end
         2'b01: begin
            v = (rdu >> (16 * (int'(a) / 2))) % 65536;
            if (!nl[2] && v >= 32768) v = v + 32'hFFFF_0000;
         end
         default: v = rdu;
      endcase
      return v;
   endfunction

   // Reference store lane replication and strobes
   function automatic logic [35:0] model_store(input logic [31:0] d, input logic [1:0] sz, input logic [1:0] a);
      int unsigned du;
      int unsigned data;
      int unsigned strb;
      du = d;
      case (sz)
         2'b00: begin data = (du % 256) * 32'h0101_0101;   strb = 1 << a; end
         2'b01: begin data = (du % 65536) * 32'h0001_0001; strb = 3 << a; end
         default: begin data = du; strb = 15; end
      endcase
      return {strb[3:0], data};
   endfunction

   // One Memory2 instruction: drive it, queue the expectation, play the DCache side
   task automatic do_txn(input logic [1:0] rw, input logic [2:0] nl, input logic [31:0] addr,
                         input logic [31:0] data, input logic hit, input logic [19:0] ppn,
                         input logic [31:0] rdata, input int waits, input int fmode, input int flush_at);
      exp_t        e;
      logic        mis;
      logic        is_mem;
      logic [35:0] st;
      @(posedge clk); #1;
      req_valid     = 1'b1;
      memory_rw     = rw;
      number_length = nl;
      v_addr        = addr;
      store_data    = data;
      tlb_hit       = hit;
      tlb_ppn       = ppn;
      flush         = (fmode == 1);
      cache_ready   = 1'b0;
      cache_read    = $urandom;
      is_mem = (rw == 2'b01) || (rw == 2'b10);
      mis = (nl[1:0] == 2'b01 && addr[0]) || (nl[1:0] >= 2'b10 && addr[1:0] != 2'b00);
      e.paddr = '0; e.rw = '0; e.wdata = '0; e.wstrb = '0; e.result = '0; e.waits = 0;
      e.kind = K_ACC;
      if (!is_mem || fmode == 1) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         flush = 1'b0;
      end else if (mis || !hit) begin
         e.kind = mis ? K_ALE : K_TLBR;
         sb.push_back(e);
         @(posedge clk); #1;
         req_valid = 1'b0;
      end else begin
         st = model_store(data, nl[1:0], addr[1:0]);
         e.paddr = {ppn, addr[11:0]};
         e.rw    = rw;
         e.wdata = st[31:0];
         e.wstrb = (rw == 2'b10) ? st[35:32] : 4'b0000;
         e.waits = waits;
         if (rw == 2'b01 && fmode != 2) model_last = model_load(rdata, nl, addr[1:0]);
         e.result = model_last;
         sb.push_back(e);
         for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            flush       = (fmode == 2) && (k == flush_at);
            cache_ready = (k == waits);
            cache_read  = (k == waits) ? rdata : $urandom;
         end
         @(posedge clk); #1;
         cache_ready = 1'b0;
         flush       = 1'b0;
         req_valid   = 1'b0;
      end
   endtask

   // Monitor: pops an expectation whenever the DUT raises an exception or a new request
   initial begin
      exp_t it;
      exp_t cur;
      int   stall_run;
      int   valid_run;
      logic prev_valid;
      logic stable;
      stall_run = 0; valid_run = 0; prev_valid = 1'b0; stable = 1'b1;
      cur.kind = K_ACC; cur.paddr = '0; cur.rw = '0; cur.wdata = '0; cur.wstrb = '0;
      cur.result = '0; cur.waits = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0; stall_run = 0; valid_run = 0;
         end else begin
            if (excp_ale || excp_tlbr) begin
               if (sb.size() == 0) check("unexpected_excp", 32'({excp_ale, excp_tlbr}), 32'd0);
               else begin
                  it = sb.pop_front();
                  check("excp_ale", 32'(excp_ale), 32'(it.kind == K_ALE));
                  check("excp_tlbr", 32'(excp_tlbr), 32'(it.kind == K_TLBR));
                  check("excp_no_req", 32'({stall, p_addr_valid}), 32'd0);
               end
            end
            if (p_addr_valid && !prev_valid) begin
               if (sb.size() == 0) check("unexpected_req", 32'(p_addr_valid), 32'd0);
               else begin
                  it = sb.pop_front();
                  check("req_expected", 32'(p_addr_valid), 32'(it.kind == K_ACC));
                  check("p_addr", p_addr, it.paddr);
                  check("cache_rw", 32'(cache_rw), 32'(it.rw));
                  check("cache_wstrb", 32'(cache_wstrb), 32'(it.wstrb));
                  if (it.rw == 2'b10) check("cache_write", cache_write, it.wdata);
                  cur = it;
                  stable = 1'b1;
               end
            end else if (p_addr_valid) begin
               if (p_addr !== cur.paddr || cache_rw !== cur.rw || cache_wstrb !== cur.wstrb ||
                   (cur.rw == 2'b10 && cache_write !== cur.wdata)) stable = 1'b0;
            end
            if (!p_addr_valid && prev_valid) begin
               check("req_stable", 32'(stable), 32'd1);
               check("valid_cycles", valid_run, cur.waits + 1);
               check("stall_cycles", stall_run, cur.waits + 2);
               check("mem_result", mem_result, cur.result);
            end
            valid_run  = p_addr_valid ? valid_run + 1 : 0;
            stall_run  = stall ? stall_run + 1 : 0;
            prev_valid = p_addr_valid;
         end
      end
   end

   // Driver: reset, directed plan items, reset-in-BUSY, then random traffic
   initial begin
      logic [1:0]  rw;
      logic [2:0]  nl;
      logic [31:0] addr;
      int          waits;
      int          fm;
      int          fmode;
      int          flush_at;
      int          r;
      n_pass = 0; n_total = 0; model_last = '0;
      rst = 1'b1; req_valid = 1'b0; memory_rw = '0; number_length = '0; v_addr = '0;
      store_data = '0; flush = 1'b0; tlb_hit = 1'b0; tlb_ppn = '0; cache_ready = 1'b0;
      cache_read = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", {p_addr | cache_write | mem_result}, 32'd0);
      check("rst_ctrl", 32'({p_addr_valid, cache_rw, cache_wstrb, stall, excp_ale, excp_tlbr}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("idle_state", 32'({p_addr_valid, stall}), 32'd0);
      check("idle_regs", p_addr | mem_result | cache_write, 32'd0);

      do_txn(2'b01, 3'b010, 32'h0000_1004, 32'h0, 1'b1, 20'h12345, 32'hDEAD_BEEF, 0, 0, 0);
      do_txn(2'b01, 3'b000, 32'h0000_2003, 32'h0, 1'b1, 20'h00ABC, 32'h80FF_0000, 1, 0, 0);
      do_txn(2'b01, 3'b100, 32'h0000_2003, 32'h0, 1'b1, 20'h00ABC, 32'h80FF_0000, 0, 0, 0);
      do_txn(2'b10, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 1'b1, 20'h00055, 32'h0, 3, 0, 0);
      do_txn(2'b01, 3'b010, 32'h0000_4002, 32'h0, 1'b1, 20'h00001, 32'h0, 0, 0, 0);
      do_txn(2'b01, 3'b010, 32'h0000_4000, 32'h0, 1'b0, 20'h00001, 32'h0, 0, 0, 0);
      do_txn(2'b01, 3'b010, 32'h0000_5008, 32'h0, 1'b1, 20'h00777, 32'h1234_5678, 2, 2, 0);
      do_txn(2'b00, 3'b010, 32'h0000_4002, 32'h0, 1'b0, 20'h00001, 32'h0, 0, 0, 0);
      do_txn(2'b11, 3'b010, 32'h0000_4002, 32'h0, 1'b1, 20'h00001, 32'h0, 0, 0, 0);
      do_txn(2'b01, 3'b010, 32'h0000_4001, 32'h0, 1'b0, 20'h00001, 32'h0, 0, 1, 0);

      // Reset in the middle of an outstanding load
      @(posedge clk); #1;
      req_valid = 1'b1; memory_rw = 2'b01; number_length = 3'b010; v_addr = 32'h0000_6000;
      tlb_hit = 1'b1; tlb_ppn = 20'h00F0F; flush = 1'b0;
      sb.push_back('{K_ACC, 32'h00F0_F000, 2'b01, 32'h0, 4'b0000, 32'h0, 0});
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_busy_data", p_addr | cache_write | mem_result, 32'd0);
      check("rst_busy_ctrl", 32'({p_addr_valid, cache_rw, cache_wstrb, stall, excp_ale, excp_tlbr}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 1'b0;
      model_last = '0;
      @(negedge clk);
      check("post_rst_idle", 32'({p_addr_valid, stall}), 32'd0);
      check("post_rst_regs", p_addr | mem_result, 32'd0);
      do_txn(2'b01, 3'b001, 32'h0000_7002, 32'h0, 1'b1, 20'h00321, 32'h8001_7FFF, 1, 0, 0);

      for (int i = 0; i < 200; i++) begin
         r  = $urandom_range(0, 9);
         rw = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
         nl = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (nl[1:0] == 2'b01) addr[0] = 1'b0;
            else if (nl[1:0] != 2'b00) addr[1:0] = 2'b00;
         end
         waits    = $urandom_range(0, 5);
         fm       = $urandom_range(0, 9);
         fmode    = (fm == 0) ? 1 : (fm < 3 && waits > 0) ? 2 : 0;
         flush_at = (waits > 0) ? $urandom_range(0, waits - 1) : 0;
         do_txn(rw, nl, addr, $urandom, ($urandom_range(0, 7) != 0), 20'($urandom),
                $urandom, waits, fmode, flush_at);
      end

      repeat (4) @(posedge clk);
      check("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
